// File: rtl/bullet_hit_detect.sv
// Bullet flight monitor: retires the bullet at the screen edge or on an enemy
// tank hit, keeps the BCD hit score and times the hit-flash flag.
module bullet_hit_detect #(
  parameter int X_MAX        = 159,
  parameter int Y_MAX        = 119,
  parameter int TANK_W       = 5,
  parameter int FLASH_CYCLES = 25000000
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [7:0] bx,
  input  logic [6:0] by,
  input  logic [2:0] bd,
  input  logic [7:0] ex,
  input  logic [6:0] ey,
  output logic       ready,
  output logic       hit,
  output logic       flash,
  output logic [7:0] score
);

  localparam logic [7:0]  X_LIM      = 8'(X_MAX);
  localparam logic [6:0]  Y_LIM      = 7'(Y_MAX);
  localparam logic [8:0]  X_SPAN     = 9'(TANK_W - 1);
  localparam logic [7:0]  Y_SPAN     = 8'(TANK_W - 1);
  localparam logic [24:0] FLASH_LOAD = 25'(FLASH_CYCLES);

  typedef enum logic [1:0] {IDLE, FLIGHT, RETIRE} state_t;

  state_t      state_reg;
  logic [24:0] flash_cnt_reg;
  logic        ready_reg;
  logic        hit_reg;
  logic [7:0]  score_reg;

  logic [8:0]  x_hi;
  logic [7:0]  y_hi;
  logic        in_tank;
  logic        at_edge;
  logic [7:0]  score_next;

  // Upper bounds are one bit wider so a tank near the screen edge never wraps.
  always_comb begin
    x_hi    = {1'b0, ex} + X_SPAN;
    y_hi    = {1'b0, ey} + Y_SPAN;
    in_tank = (bx >= ex) && ({1'b0, bx} <= x_hi) &&
              (by >= ey) && ({1'b0, by} <= y_hi);
  end

  always_comb begin
    at_edge = 1'b0;
    case (bd[1:0])
      2'd0:    at_edge = (by == 7'd0);
      2'd1:    at_edge = (by >= Y_LIM);
      2'd2:    at_edge = (bx == 8'd0);
      default: at_edge = (bx >= X_LIM);
    endcase
  end

  // BCD increment that saturates at 99.
  always_comb begin
    score_next = score_reg;
    if (score_reg != 8'h99) begin
      if (score_reg[3:0] == 4'd9)
        score_next = {score_reg[7:4] + 4'd1, 4'd0};
      else
        score_next = {score_reg[7:4], score_reg[3:0] + 4'd1};
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_reg     <= IDLE;
      ready_reg     <= 1'b0;
      hit_reg       <= 1'b0;
      score_reg     <= 8'h00;
      flash_cnt_reg <= '0;
    end else begin
      hit_reg <= 1'b0;
      if (flash_cnt_reg != '0)
        flash_cnt_reg <= flash_cnt_reg - 25'd1;

      case (state_reg)
        IDLE: begin
          ready_reg <= 1'b0;
          if (bd[2])
            state_reg <= FLIGHT;
        end
        FLIGHT: begin
          if (in_tank) begin
            state_reg     <= RETIRE;
            ready_reg     <= 1'b1;
            hit_reg       <= 1'b1;
            score_reg     <= score_next;
            flash_cnt_reg <= FLASH_LOAD;
          end else if (at_edge) begin
            state_reg <= RETIRE;
            ready_reg <= 1'b1;
          end else if (!bd[2]) begin
            state_reg <= IDLE;
          end
        end
        RETIRE: begin
          // Positions are ignored here, so one flight scores at most once.
          if (!bd[2]) begin
            state_reg <= IDLE;
            ready_reg <= 1'b0;
          end
        end
        default: begin
          state_reg <= IDLE;
          ready_reg <= 1'b0;
        end
      endcase
    end
  end

  assign ready = ready_reg;
  assign hit   = hit_reg;
  assign flash = (flash_cnt_reg != '0);
  assign score = score_reg;

endmodule

// File: tb/tb_bullet_hit_detect.sv
// Directed bench for bullet_hit_detect: edge retire, tank hits, BCD score,
// flash timing and the corner bound case.
module tb_bullet_hit_detect;

  logic       clk = 1'b0;
  logic       reset;
  logic [7:0] bx;
  logic [6:0] by;
  logic [2:0] bd;
  logic [7:0] ex;
  logic [6:0] ey;
  logic       ready;
  logic       hit;
  logic       flash;
  logic [7:0] score;

  int tests = 0;
  int fails = 0;
  int hits_done = 0;

  bullet_hit_detect #(
    .X_MAX(159), .Y_MAX(119), .TANK_W(5), .FLASH_CYCLES(10)
  ) dut (
    .clk(clk), .reset(reset), .bx(bx), .by(by), .bd(bd), .ex(ex), .ey(ey),
    .ready(ready), .hit(hit), .flash(flash), .score(score)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [7:0] bcd_of(input int n);
    int v;
    v = (n > 99) ? 99 : n;
    return 8'((v / 10) * 16 + (v % 10));
  endfunction

  // One complete flight from IDLE into the tank at (40,30); leaves the FSM in IDLE.
  task automatic tank_shot();
    bx = 8'd42; by = 7'd32; bd = 3'b100;
    step();
    step();
    hits_done++;
    check("shot_hit", {7'd0, hit}, 8'd1);
    check("shot_score", score, bcd_of(hits_done));
    $display("[TB] shot %0d score=%0h hit=%0b", hits_done, score, hit);
    bd = 3'b000;
    step();
  endtask

  initial begin
    reset = 1'b1; bd = 3'b111; bx = 8'd100; by = 7'd60; ex = 8'd200; ey = 7'd100;
    step(); step();
    check("rst_ready", {7'd0, ready}, 8'd0);
    check("rst_hit",   {7'd0, hit},   8'd0);
    check("rst_flash", {7'd0, flash}, 8'd0);
    check("rst_score", score, 8'h00);
    $display("[TB] reset ready=%0b hit=%0b flash=%0b score=%0h", ready, hit, flash, score);
    reset = 1'b0;
    step(); step(); step();
    check("flight_ready", {7'd0, ready}, 8'd0);

    // Right edge retire
    for (int i = 150; i <= 159; i++) begin
      bx = 8'(i);
      step();
      check("edge_ready", {7'd0, ready}, (i == 159) ? 8'd1 : 8'd0);
      check("edge_hit", {7'd0, hit}, 8'd0);
      $display("[TB] edge bx=%0d ready=%0b hit=%0b", i, ready, hit);
    end
    step();
    check("edge_hold", {7'd0, ready}, 8'd1);
    check("edge_score", score, 8'h00);
    bd = 3'b000;
    step();
    check("edge_release", {7'd0, ready}, 8'd0);
    step();

    // Tank hit, bullet moving up through the tank's bottom row
    ex = 8'd40; ey = 7'd30; bx = 8'd42; by = 7'd40; bd = 3'b100;
    step();
    for (int y = 40; y >= 34; y--) begin
      by = 7'(y);
      step();
      check("tank_hit", {7'd0, hit}, (y == 34) ? 8'd1 : 8'd0);
      check("tank_ready", {7'd0, ready}, (y == 34) ? 8'd1 : 8'd0);
      $display("[TB] tank by=%0d hit=%0b ready=%0b score=%0h", y, hit, ready, score);
    end
    hits_done = 1;
    check("tank_score", score, 8'h01);
    check("tank_flash", {7'd0, flash}, 8'd1);

    // Sit inside the tank: no second hit, flash runs out after 10 clocks
    by = 7'd33;
    for (int j = 1; j <= 20; j++) begin
      step();
      check("hold_hit", {7'd0, hit}, 8'd0);
      check("hold_ready", {7'd0, ready}, 8'd1);
      check("hold_flash", {7'd0, flash}, (j < 10) ? 8'd1 : 8'd0);
      $display("[TB] hold %0d ready=%0b hit=%0b flash=%0b", j, ready, hit, flash);
    end
    check("hold_score", score, 8'h01);
    bd = 3'b000;
    step();
    check("hold_release", {7'd0, ready}, 8'd0);

    // Score through 09, 10 and on to saturation at 99
    while (hits_done < 100) tank_shot();
    check("sat_score", score, 8'h99);

    // Corner case: tank against the right edge
    reset = 1'b1; step(); reset = 1'b0;
    check("rst2_score", score, 8'h00);
    ex = 8'd155; ey = 7'd0; bx = 8'd159; by = 7'd2; bd = 3'b111;
    step(); step();
    check("corner_hit", {7'd0, hit}, 8'd1);
    check("corner_ready", {7'd0, ready}, 8'd1);
    check("corner_score", score, 8'h01);
    $display("[TB] corner ex=155 hit=%0b ready=%0b score=%0h", hit, ready, score);
    bd = 3'b000; step(); step();
    ex = 8'd255; bd = 3'b111;
    step(); step();
    check("corner2_hit", {7'd0, hit}, 8'd0);
    check("corner2_ready", {7'd0, ready}, 8'd1);
    check("corner2_score", score, 8'h01);
    $display("[TB] corner ex=255 hit=%0b ready=%0b score=%0h", hit, ready, score);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
